axil_cmd_master: RTL and testbench

AXI4-Lite master that turns single register-access commands (read or write, one word) into AXI4-Lite transactions and returns one response per command. It sits directly upstream of `axi_slave` and drives its read and write channels. It is the synthesizable replacement for the bench-side `axi_write`/`axi_read` tasks, so control logic, or a bench, can issue register accesses through a valid/ready command port.

---
 rtl/axil_cmd_master.sv | 229 ++++++++++++++++++++++
 tb/tb_axil_cmd_master.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cmd_master.sv
// AXI4-Lite command master: turns one valid/ready register-access command
// into a single AXI4-Lite read or write and returns one response per command.
module axil_cmd_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                busy,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [2:0]          AWPROT,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic                ARVALID,
  input  logic                ARREADY,
  output logic [2:0]          ARPROT,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RVALID,
  output logic                RREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RSP
  } state_e;

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                arvalid_q, arvalid_d;
  logic                bready_q, bready_d;
  logic                rready_q, rready_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;

  logic cmd_acc, misaligned, aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_both;

  assign cmd_acc    = cmd_valid & cmd_ready_q;
  assign misaligned = cmd_addr[1:0] != 2'b00;
  assign aw_hs      = awvalid_q & AWREADY;
  assign w_hs       = wvalid_q & WREADY;
  assign b_hs       = BVALID & bready_q;
  assign ar_hs      = arvalid_q & ARREADY;
  assign r_hs       = RVALID & rready_q;
  assign wr_both    = (aw_done_q | aw_hs) & (w_done_q | w_hs);

  // State and registered outputs; reset clears everything asynchronously
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
    end
  end

  // Next-state: one command in flight, each phase advances on its handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          if (misaligned)     state_d = S_RSP;
          else if (cmd_write) state_d = S_WR;
          else                state_d = S_RD_ADDR;
        end
      end
      S_WR:      if (wr_both) state_d = S_WR_RESP;
      S_WR_RESP: if (b_hs) state_d = S_RSP;
      S_RD_ADDR: if (ar_hs) state_d = S_RD_DATA;
      S_RD_DATA: if (r_hs) state_d = S_RSP;
      S_RSP:     if (rsp_valid_q && rsp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output next values: load on accept, drop each VALID/READY after its handshake
  always_comb begin
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          rsp_write_d = cmd_write;
          if (misaligned) begin
            rsp_resp_d  = 2'b10;
            rsp_rdata_d = '0;
          end else if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WR: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (wr_both) bready_d = 1'b1;
      end
      S_WR_RESP: begin
        if (b_hs) begin
          rsp_resp_d  = BRESP;
          rsp_rdata_d = '0;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
        end
      end
      S_RD_ADDR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      S_RD_DATA: begin
        if (r_hs) begin
          rsp_rdata_d = RDATA;
          rsp_resp_d  = RRESP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
        end
      end
      S_RSP: begin
        // A misaligned command enters RSP with rsp_valid still low; it is raised one cycle later
        if (!rsp_valid_q)    rsp_valid_d = 1'b1;
        else if (rsp_ready)  rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign busy      = (state_q != S_IDLE);
  assign AWADDR    = awaddr_q;
  assign AWVALID   = awvalid_q;
  assign AWPROT    = 3'b000;
  assign WDATA     = wdata_q;
  assign WSTRB     = '1;
  assign WVALID    = wvalid_q;
  assign BREADY    = bready_q;
  assign ARADDR    = araddr_q;
  assign ARVALID   = arvalid_q;
  assign ARPROT    = 3'b000;
  assign RREADY    = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: reactive AXI-Lite slave with per-command wait
// counts, a cycle-timing model of the master, and directed commands.
module tb_axil_cmd_master;

  logic        ACLK;
  logic        ARESETN;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;

  axil_cmd_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWPROT(AWPROT),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARPROT(ARPROT),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- slave ----------------
  int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0, rsp_wait = 0;
  logic [1:0]  slave_resp = 2'b00;
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, rsp_cnt;
  logic        aw_got, w_got, b_arm, r_arm;
  logic [31:0] sl_awaddr, sl_wdata, r_addr;
  logic [31:0] smem [16];
  logic        aw_fire, w_fire;
  logic [31:0] wr_addr_c, wr_data_c;

  assign aw_fire   = AWVALID && AWREADY;
  assign w_fire    = WVALID && WREADY;
  assign wr_addr_c = aw_fire ? AWADDR : sl_awaddr;
  assign wr_data_c = w_fire ? WDATA : sl_wdata;
  assign AWREADY   = AWVALID && (aw_cnt == aw_wait);
  assign WREADY    = WVALID && (w_cnt == w_wait);
  assign ARREADY   = ARVALID && (ar_cnt == ar_wait);
  assign BVALID    = b_arm && (b_cnt == b_wait);
  assign RVALID    = r_arm && (r_cnt == r_wait);
  assign BRESP     = slave_resp;
  assign RRESP     = slave_resp;
  assign RDATA     = smem[r_addr[5:2]];
  assign rsp_ready = rsp_valid && (rsp_cnt == rsp_wait);

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0; rsp_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_arm <= 1'b0; r_arm <= 1'b0;
      sl_awaddr <= '0; sl_wdata <= '0; r_addr <= '0;
      for (int i = 0; i < 16; i++) smem[i] <= '0;
    end else begin
      if (aw_fire) begin aw_got <= 1'b1; sl_awaddr <= AWADDR; aw_cnt <= 0; end
      else if (AWVALID) aw_cnt <= aw_cnt + 1;
      if (w_fire) begin w_got <= 1'b1; sl_wdata <= WDATA; w_cnt <= 0; end
      else if (WVALID) w_cnt <= w_cnt + 1;
      if (!b_arm && (aw_got || aw_fire) && (w_got || w_fire)) begin
        b_arm <= 1'b1;
        b_cnt <= 0;
        smem[wr_addr_c[5:2]] <= wr_data_c;
      end else if (b_arm) begin
        if (BVALID && BREADY) begin b_arm <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; end
        else if (b_cnt < b_wait) b_cnt <= b_cnt + 1;
      end
      if (ARVALID && ARREADY) begin r_arm <= 1'b1; r_cnt <= 0; r_addr <= ARADDR; ar_cnt <= 0; end
      else begin
        if (ARVALID) ar_cnt <= ar_cnt + 1;
        if (r_arm) begin
          if (RVALID && RREADY) r_arm <= 1'b0;
          else if (r_cnt < r_wait) r_cnt <= r_cnt + 1;
        end
      end
      if (rsp_valid && !rsp_ready) rsp_cnt <= rsp_cnt + 1;
      else rsp_cnt <= 0;
    end
  end

  // ---------------- timing model ----------------
  // m_kind: 0 none, 1 write, 2 read, 3 misaligned
  int          m_kind = 0, m_n = 0, idle_from = 1000000;
  int          m_aww, m_ww, m_bw, m_arw, m_rw, m_rspw;
  logic [31:0] m_addr, m_data, m_rdata;
  logic [1:0]  m_resp;
  logic        m_write;
  logic        rst_active = 1'b1;
  logic [31:0] mmem [16];

  // k: 0 AWVALID 1 WVALID 2 ARVALID 3 BREADY 4 RREADY 5 rsp_valid 6 busy 7 cmd_ready
  function automatic bit ev(input int t, input int k);
    int s0, s1, s2, s3, r;
    bit aw, w, ar, b, rr, rv;
    aw = 0; w = 0; ar = 0; b = 0; rr = 0; rv = 0;
    if (m_kind == 1) begin
      s0 = 1 + m_aww; s1 = 1 + m_ww; s2 = (s0 > s1) ? s0 : s1;
      s3 = s2 + 1 + m_bw; r = s3 + 1 + m_rspw;
      aw = t < s0; w = t < s1; b = (t >= s2) && (t < s3);
    end else if (m_kind == 2) begin
      s0 = 1 + m_arw; s3 = s0 + 1 + m_rw; r = s3 + 1 + m_rspw;
      ar = t < s0; rr = (t >= s0) && (t < s3);
    end else begin
      s3 = 1; r = 2 + m_rspw;
    end
    rv = (t >= s3) && (t < r);
    case (k)
      0: return aw;
      1: return w;
      2: return ar;
      3: return b;
      4: return rr;
      5: return rv;
      6: return t < r;
      default: return t >= r;
    endcase
  endfunction

  // Per-cycle compare against the timing model, sampled mid-cycle
  always @(negedge ACLK) begin
    if (rst_active) begin
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_valids", {AWVALID, WVALID, ARVALID}, 0);
      chk("rst_readys", {BREADY, RREADY}, 0);
    end else if (m_kind == 0) begin
      chk("idle_cmd_ready", cmd_ready, cyc >= idle_from);
      chk("idle_busy", busy, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_axi", {AWVALID, WVALID, ARVALID, BREADY, RREADY}, 0);
    end else begin
      chk("AWVALID", AWVALID, ev(cyc - m_n, 0));
      chk("WVALID", WVALID, ev(cyc - m_n, 1));
      chk("ARVALID", ARVALID, ev(cyc - m_n, 2));
      chk("BREADY", BREADY, ev(cyc - m_n, 3));
      chk("RREADY", RREADY, ev(cyc - m_n, 4));
      chk("rsp_valid", rsp_valid, ev(cyc - m_n, 5));
      chk("busy", busy, ev(cyc - m_n, 6));
      chk("cmd_ready", cmd_ready, ev(cyc - m_n, 7));
      chk("prot", {AWPROT, ARPROT}, 0);
      if (ev(cyc - m_n, 0)) chk("AWADDR", AWADDR, m_addr);
      if (ev(cyc - m_n, 1)) begin
        chk("WDATA", WDATA, m_data);
        chk("WSTRB", WSTRB, 4'hF);
      end
      if (ev(cyc - m_n, 2)) chk("ARADDR", ARADDR, m_addr);
      if (ev(cyc - m_n, 5)) begin
        chk("rsp_write", rsp_write, m_write);
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_resp", rsp_resp, m_resp);
      end
    end
  end

  // ---------------- directed driver ----------------
  task automatic drive_accept(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                              output bit ok);
    bit mis;
    mis = (addr[1:0] != 2'b00);
    @(negedge ACLK); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready === 1'b1) begin ok = 1; break; end
      @(negedge ACLK); #1;
    end
    if (!ok) begin
      chk("cmd_accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge ACLK); #1;
    m_n = cyc; m_write = wr; m_addr = addr; m_data = data;
    m_aww = aw_wait; m_ww = w_wait; m_bw = b_wait; m_arw = ar_wait; m_rw = r_wait; m_rspw = rsp_wait;
    m_kind = mis ? 3 : (wr ? 1 : 2);
    m_resp = mis ? 2'b10 : slave_resp;
    m_rdata = (mis || wr) ? 32'h0 : mmem[addr[5:2]];
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~data;
  endtask

  task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input int aww, input int ww, input int bw, input int arw,
                        input int rw, input int rspw, input logic [1:0] sresp,
                        input int exp_lat, input logic [31:0] exp_rdata, input logic [1:0] exp_resp);
    bit ok, got;
    int lat;
    logic [31:0] a_rdata;
    logic [1:0]  a_resp;
    logic        a_write;
    aw_wait = aww; w_wait = ww; b_wait = bw; ar_wait = arw; r_wait = rw; rsp_wait = rspw;
    slave_resp = sresp;
    drive_accept(wr, addr, data, ok);
    if (!ok) return;
    lat = -1; got = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge ACLK); #1;
      if (rsp_valid === 1'b1 && lat < 0) lat = t;
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        got = 1; a_rdata = rsp_rdata; a_resp = rsp_resp; a_write = rsp_write;
        break;
      end
    end
    if (!got) begin
      chk("rsp_timeout", 0, 1);
      return;
    end
    chk("rsp_latency", lat, exp_lat);
    chk("rsp_rdata_lit", a_rdata, exp_rdata);
    chk("rsp_resp_lit", a_resp, exp_resp);
    chk("rsp_write_lit", a_write, wr);
    @(posedge ACLK); #1;
    if (wr && addr[1:0] == 2'b00) mmem[addr[5:2]] = data;
  endtask

  initial begin
    bit ok;
    ARESETN = 1'b0; rst_active = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    for (int i = 0; i < 16; i++) mmem[i] = '0;
    repeat (3) @(negedge ACLK);
    #1;
    chk("rst_rsp_fields", {rsp_rdata, rsp_resp, rsp_write}, 0);
    chk("rst_addrs", {AWADDR, ARADDR}, 0);
    chk("rst_wdata", WDATA, 0);
    #1;
    ARESETN = 1'b1; rst_active = 1'b0; idle_from = cyc + 1;

    //     wr addr          data          aww ww bw arw rw rspw resp  lat rdata         resp
    do_cmd(1, 32'h43C00004, 32'hF200000B, 0, 0, 0, 0, 0, 0, 2'b00, 2, 32'h0,        2'b00);
    do_cmd(0, 32'h43C00004, 32'h0,        0, 0, 0, 0, 0, 0, 2'b00, 2, 32'hF200000B, 2'b00);
    do_cmd(1, 32'h43C00008, 32'h11112222, 0, 3, 0, 0, 0, 0, 2'b00, 5, 32'h0,        2'b00);
    do_cmd(1, 32'h43C0000C, 32'h33334444, 3, 0, 0, 0, 0, 0, 2'b00, 5, 32'h0,        2'b00);
    do_cmd(0, 32'h43C00002, 32'h0,        0, 0, 0, 0, 0, 0, 2'b00, 1, 32'h0,        2'b10);
    do_cmd(0, 32'h43C00008, 32'h0,        0, 0, 0, 0, 1, 5, 2'b10, 3, 32'h11112222, 2'b10);
    do_cmd(1, 32'h43C00010, 32'h55556666, 0, 0, 2, 0, 0, 0, 2'b11, 4, 32'h0,        2'b11);
    do_cmd(1, 32'h43C00001, 32'h77778888, 0, 0, 0, 0, 0, 1, 2'b00, 1, 32'h0,        2'b10);

    // Reset while the write address/data are still waiting for READY
    aw_wait = 6; w_wait = 6; b_wait = 0; rsp_wait = 0; slave_resp = 2'b00;
    drive_accept(1, 32'h43C00000, 32'hCAFEF00D, ok);
    @(negedge ACLK); @(negedge ACLK); #2;
    rst_active = 1'b1; ARESETN = 1'b0;
    #1;
    chk("async_AWVALID", AWVALID, 0);
    chk("async_WVALID", WVALID, 0);
    chk("async_busy", busy, 0);
    chk("async_cmd_ready", cmd_ready, 0);
    m_kind = 0;
    for (int i = 0; i < 16; i++) mmem[i] = '0;
    @(negedge ACLK); @(negedge ACLK); #2;
    ARESETN = 1'b1; rst_active = 1'b0; idle_from = cyc + 1;

    do_cmd(0, 32'h43C00000, 32'h0,        0, 0, 0, 0, 0, 0, 2'b00, 2, 32'h0,        2'b00);
    do_cmd(1, 32'h43C00014, 32'hA5A55A5A, 0, 0, 0, 0, 0, 2, 2'b00, 2, 32'h0,        2'b00);
    do_cmd(0, 32'h43C00014, 32'h0,        0, 0, 0, 2, 0, 0, 2'b00, 4, 32'hA5A55A5A, 2'b00);
    do_cmd(0, 32'h43C0000C, 32'h0,        0, 0, 0, 1, 2, 0, 2'b01, 5, 32'h0,        2'b01);

    repeat (3) @(negedge ACLK);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errs, checks);
    $fatal(1);
  end

endmodule
